// File: rtl/image_io_pkg.sv
// Shared image I/O definitions: frame geometry, default RAM address/data widths
// and the state encoding of the DRAM-to-UART frame reader.
// No ports; imported by the reader, its interface and its sub-module.
package image_io_pkg;

  localparam int IMG_W      = 512;
  localparam int IMG_H      = 512;
  localparam int IMG_ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int IMG_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDWAIT,
    ST_LOAD,
    ST_SEND,
    ST_TXWAIT,
    ST_NEXT,
    ST_DONE
  } rd_state_t;

  // Extra RDWAIT cycles after the first one, as a down-counter preset
  // (latency 1 never enters RDWAIT, latency 2 spends one cycle there).
  function automatic logic [1:0] rdwait_preset(input int rd_lat);
    return (rd_lat > 1) ? 2'(rd_lat - 2) : 2'd0;
  endfunction

endpackage

// File: rtl/dram_tx_reader_if.sv
// Bus between the frame reader, the image RAM read port and the UART transmitter.
//   ram_addr  : read address to the RAM (reader drives)
//   ram_rdata : RAM read data (RAM drives)
//   tx_dv     : one-cycle "byte valid, start transmitting" (reader drives)
//   tx_byte   : byte for the transmitter (reader drives)
//   tx_done   : one-cycle end-of-stop-bit pulse (transmitter drives)
// master = reader side, slave = RAM/transmitter side.
interface dram_tx_reader_if
  import image_io_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = IMG_DATA_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              tx_dv;
  logic [DATA_W-1:0] tx_byte;
  logic              tx_done;

  modport master (
    output ram_addr, tx_dv, tx_byte,
    input  ram_rdata, tx_done
  );

  modport slave (
    input  ram_addr, tx_dv, tx_byte,
    output ram_rdata, tx_done
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Push-button start conditioning: two-flop synchronizer into the clk domain
// followed by a falling-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (all flops preset to 1 = released)
//   btn_n : raw active-low button, asynchronous to clk
//   fall  : one-cycle pulse on a synchronized 1->0 transition
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/dram_tx_reader.sv
// Streams a frame of bytes from a synchronous image RAM to a UART transmitter,
// one byte per transmitter handshake.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start_n    : raw active-low start button (synchronized internally)
//   abort      : synchronous stop request
//   frame_len  : bytes to send, sampled on the accepted start
//   bus        : RAM read port + transmitter handshake (master side)
//   busy       : high from accepted start until back in IDLE
//   fin        : one-cycle pulse when the frame ends (complete or aborted)
//   sent_cnt   : bytes acknowledged by tx_done in the current frame
module dram_tx_reader
  import image_io_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = IMG_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_n,
  input  logic              abort,
  input  logic [ADDR_W:0]   frame_len,
  dram_tx_reader_if.master  bus,
  output logic              busy,
  output logic              fin,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam logic [1:0] WAIT_PRESET = rdwait_preset(RD_LAT);

  logic start_fall;

  btn_edge_sync u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (start_n),
    .fall  (start_fall)
  );

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   len_q,   len_d;
  logic [ADDR_W:0]   sent_q,  sent_d;
  logic [DATA_W-1:0] byte_q,  byte_d;
  logic [1:0]        wait_q,  wait_d;
  logic              abort_pend_q, abort_pend_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    sent_d       = sent_q;
    byte_d       = byte_q;
    wait_d       = wait_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here; start edges are only looked at in IDLE,
        // so edges arriving mid-frame are simply dropped.
        if (start_fall) begin
          len_d        = frame_len;
          addr_d       = '0;
          sent_d       = '0;
          abort_pend_d = 1'b0;
          state_d      = (frame_len == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (RD_LAT == 1) begin
          state_d = ST_LOAD;
        end else begin
          wait_d  = WAIT_PRESET;
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        // ram_addr is held by addr_q, so the RAM output settles on this word.
        if (abort) begin
          state_d = ST_DONE;
        end else if (wait_q == 2'd0) begin
          state_d = ST_LOAD;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          byte_d  = bus.ram_rdata;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // A byte handed to the transmitter is always allowed to finish.
        if (abort) abort_pend_d = 1'b1;
        state_d = ST_TXWAIT;
      end
      ST_TXWAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (bus.tx_done) begin
          sent_d  = sent_q + 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // The address is not advanced past the last byte, so it still shows
        // the final location once the frame is over.
        if (abort_pend_q || abort || (sent_q == len_q)) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      sent_q       <= '0;
      byte_q       <= '0;
      wait_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      sent_q       <= sent_d;
      byte_q       <= byte_d;
      wait_q       <= wait_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign bus.ram_addr = addr_q;
  assign bus.tx_byte  = byte_q;
  assign bus.tx_dv    = (state_q == ST_SEND);
  assign busy         = (state_q != ST_IDLE);
  assign fin          = (state_q == ST_DONE);
  assign sent_cnt     = sent_q;

endmodule
